// File: rtl/soc_interface_wb_if.sv
// Wishbone classic bus bundle between the stream bridge (master) and a slave.
interface soc_interface_wb_if #(
  parameter int unsigned WB_DATA_WIDTH = 32
);
  localparam int unsigned SEL_W     = WB_DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(SEL_W);
  localparam int unsigned ADR_W     = 36 - LANE_BITS;

  logic [ADR_W-1:0]         wb_adr_o;
  logic [WB_DATA_WIDTH-1:0] wb_dat_i;
  logic [WB_DATA_WIDTH-1:0] wb_dat_o;
  logic [SEL_W-1:0]         wb_sel_o;
  logic                     wb_we_o;
  logic                     wb_stb_o;
  logic                     wb_cyc_o;
  logic                     wb_ack_i;
  logic                     wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/soc_interface_wb.sv
// Byte-stream to Wishbone bridge: A?/B? command frames turn into byte reads/writes,
// read frames are answered with a 0x01 / data / status response frame.
module soc_interface_wb #(
  parameter int unsigned WB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                input_axis_tdata,
  input  logic                      input_axis_tvalid,
  output logic                      input_axis_tready,
  input  logic                      input_axis_tlast,
  output logic [7:0]                output_axis_tdata,
  output logic                      output_axis_tvalid,
  input  logic                      output_axis_tready,
  output logic                      output_axis_tlast,
  soc_interface_wb_if.master        wb,
  output logic                      busy,
  output logic                      bus_error
);
  localparam int unsigned SEL_W     = WB_DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(SEL_W);
  localparam int unsigned LANE_W    = (LANE_BITS == 0) ? 1 : LANE_BITS;
  localparam int unsigned ADR_W     = 36 - LANE_BITS;
  localparam int unsigned TMO_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, READ, WRITE, WAIT_LAST, FINISH} state_t;

  state_t state, state_n;

  logic                     run;
  logic [35:0]              byte_addr;
  logic [1:0]               addr_cnt;
  logic                     is_read;
  logic [WB_DATA_WIDTH-1:0] wbuf;
  logic [SEL_W-1:0]         wsel;
  logic                     cache_valid;
  logic                     cache_bad;
  logic [WB_DATA_WIDTH-1:0] cache_word;
  logic [ADR_W-1:0]         cache_adr;
  logic                     pend;
  logic                     pend_last;
  logic                     start_pend;
  logic                     status_err;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     cyc;
  logic                     we;
  logic [SEL_W-1:0]         sel;
  logic [ADR_W-1:0]         adr;
  logic [WB_DATA_WIDTH-1:0] dat;
  logic [7:0]               out_data;
  logic                     out_valid;
  logic                     out_last;

  logic                     tready_c;
  logic                     cmd_c;
  logic                     addr_shift_c;
  logic                     wr_accept_c;
  logic                     wr_issue_c;
  logic                     rd_accept_c;
  logic                     rd_issue_c;
  logic                     emit_start_c;
  logic                     emit_data_c;
  logic                     emit_status_c;

  logic [LANE_W-1:0]        lane_c;
  logic [ADR_W-1:0]         word_c;
  logic                     last_lane_c;
  logic                     hit_c;
  logic                     out_free_c;
  logic                     tmo_hit_c;
  logic                     wb_done_c;
  logic                     wb_bad_c;
  logic [7:0]               rd_byte_c;
  logic [WB_DATA_WIDTH-1:0] wdat_m_c;
  logic [SEL_W-1:0]         wsel_m_c;

  assign lane_c      = byte_addr[LANE_W-1:0] & LANE_W'(SEL_W - 1);
  assign word_c      = ADR_W'(byte_addr >> LANE_BITS);
  assign last_lane_c = (lane_c == LANE_W'(SEL_W - 1));
  assign hit_c       = cache_valid && (cache_adr == word_c);
  assign out_free_c  = !out_valid || output_axis_tready;
  assign tmo_hit_c   = (TIMEOUT != 0) && ((tmo_cnt + TMO_W'(1)) == TMO_W'(TIMEOUT));
  assign wb_done_c   = cyc && (wb.wb_ack_i || wb.wb_err_i || tmo_hit_c);
  // ack together with err counts as err; a late ack on the timeout edge still wins
  assign wb_bad_c    = wb.wb_err_i || (!wb.wb_ack_i && tmo_hit_c);
  assign rd_byte_c   = cache_bad ? 8'h00 : cache_word[{lane_c, 3'b000} +: 8];

  // Merge the incoming write byte into the partially assembled word.
  always_comb begin
    wdat_m_c = wbuf;
    wdat_m_c[{lane_c, 3'b000} +: 8] = input_axis_tdata;
    wsel_m_c = wsel | (SEL_W'(1) << lane_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    tready_c      = 1'b0;
    cmd_c         = 1'b0;
    addr_shift_c  = 1'b0;
    wr_accept_c   = 1'b0;
    wr_issue_c    = 1'b0;
    rd_accept_c   = 1'b0;
    rd_issue_c    = 1'b0;
    emit_start_c  = 1'b0;
    emit_data_c   = 1'b0;
    emit_status_c = 1'b0;
    unique case (state)
      IDLE: begin
        tready_c = run && !cyc;
        if (input_axis_tvalid && tready_c && !input_axis_tlast) begin
          if (input_axis_tdata[7:4] == 4'hA || input_axis_tdata[7:4] == 4'hB) begin
            cmd_c   = 1'b1;
            state_n = ADDR;
          end else begin
            state_n = WAIT_LAST;
          end
        end
      end
      ADDR: begin
        tready_c = 1'b1;
        if (input_axis_tvalid) begin
          addr_shift_c = 1'b1;
          if (input_axis_tlast)    state_n = IDLE;
          else if (addr_cnt == 2'd3) state_n = is_read ? READ : WRITE;
        end
      end
      WRITE: begin
        tready_c = !cyc;
        if (input_axis_tvalid && tready_c) begin
          wr_accept_c = 1'b1;
          wr_issue_c  = last_lane_c || input_axis_tlast;
          if (input_axis_tlast) state_n = FINISH;
        end
      end
      READ: begin
        // one request byte in flight; a new one only once the output register is empty
        tready_c = !pend && !start_pend && !out_valid;
        rd_accept_c = input_axis_tvalid && tready_c;
        if (start_pend) begin
          emit_start_c = out_free_c;
        end else if (pend && hit_c) begin
          if (out_free_c) begin
            emit_data_c = 1'b1;
            if (pend_last) state_n = FINISH;
          end
        end else if (pend && !cyc && !out_valid) begin
          rd_issue_c = 1'b1;
        end
      end
      WAIT_LAST: begin
        tready_c = 1'b1;
        if (input_axis_tvalid && input_axis_tlast) state_n = IDLE;
      end
      FINISH: begin
        if (!cyc) begin
          if (!is_read) begin
            state_n = IDLE;
          end else if (out_free_c) begin
            emit_status_c = 1'b1;
            state_n       = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      busy        <= 1'b0;
      bus_error   <= 1'b0;
      byte_addr   <= '0;
      addr_cnt    <= '0;
      is_read     <= 1'b0;
      wbuf        <= '0;
      wsel        <= '0;
      cache_valid <= 1'b0;
      cache_bad   <= 1'b0;
      cache_word  <= '0;
      cache_adr   <= '0;
      pend        <= 1'b0;
      pend_last   <= 1'b0;
      start_pend  <= 1'b0;
      status_err  <= 1'b0;
      tmo_cnt     <= '0;
      cyc         <= 1'b0;
      we          <= 1'b0;
      sel         <= '0;
      adr         <= '0;
      dat         <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      run       <= 1'b1;
      busy      <= (state_n != IDLE);
      bus_error <= wb_done_c && wb_bad_c;

      if (cmd_c) begin
        is_read           <= (input_axis_tdata[4] == 1'b0);
        byte_addr[35:32]  <= input_axis_tdata[3:0];
        addr_cnt          <= '0;
        cache_valid       <= 1'b0;
        status_err        <= 1'b0;
        wbuf              <= '0;
        wsel              <= '0;
        pend              <= 1'b0;
        start_pend        <= 1'b0;
      end

      if (addr_shift_c) begin
        byte_addr[31:0] <= {byte_addr[23:0], input_axis_tdata};
        addr_cnt        <= 2'(addr_cnt + 2'd1);
        if (state_n == READ) start_pend <= 1'b1;
      end

      // address walks the low 32 bits only; leaving a word drops the cached copy
      if (wr_accept_c || emit_data_c) begin
        byte_addr[31:0] <= byte_addr[31:0] + 32'd1;
        if (last_lane_c) cache_valid <= 1'b0;
      end

      if (wr_accept_c) begin
        if (wr_issue_c) begin
          wbuf <= '0;
          wsel <= '0;
        end else begin
          wbuf <= wdat_m_c;
          wsel <= wsel_m_c;
        end
      end

      if (cyc) begin
        if (wb_done_c) begin
          cyc <= 1'b0;
          we  <= 1'b0;
          sel <= '0;
          if (!we) begin
            cache_valid <= 1'b1;
            cache_adr   <= adr;
            cache_word  <= wb.wb_dat_i;
            cache_bad   <= wb_bad_c;
          end
          if (wb_bad_c) status_err <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end else if (wr_issue_c) begin
        cyc     <= 1'b1;
        we      <= 1'b1;
        adr     <= word_c;
        dat     <= wdat_m_c;
        sel     <= wsel_m_c;
        tmo_cnt <= '0;
      end else if (rd_issue_c) begin
        cyc     <= 1'b1;
        we      <= 1'b0;
        adr     <= word_c;
        sel     <= '1;
        tmo_cnt <= '0;
      end

      if (rd_accept_c) begin
        pend      <= 1'b1;
        pend_last <= input_axis_tlast;
      end
      if (emit_data_c)  pend       <= 1'b0;
      if (emit_start_c) start_pend <= 1'b0;

      // single-entry response register
      if (out_valid && output_axis_tready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (emit_start_c || emit_data_c || emit_status_c) begin
        out_valid <= 1'b1;
        out_last  <= emit_status_c;
        if (emit_start_c)     out_data <= 8'h01;
        else if (emit_data_c) out_data <= rd_byte_c;
        else                  out_data <= status_err ? 8'h02 : 8'h00;
      end
    end
  end

  assign input_axis_tready  = tready_c;
  assign output_axis_tdata  = out_data;
  assign output_axis_tvalid = out_valid;
  assign output_axis_tlast  = out_last;
  assign wb.wb_cyc_o        = cyc;
  assign wb.wb_stb_o        = cyc;
  assign wb.wb_we_o         = we;
  assign wb.wb_sel_o        = sel;
  assign wb.wb_adr_o        = adr;
  assign wb.wb_dat_o        = dat;
endmodule

// File: tb/tb_soc_interface_wb.sv
// Directed bench for soc_interface_wb: write/read frames, errors, timeout, stalls, resets.
module tb_soc_interface_wb;
  localparam int unsigned DW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       input_axis_tready;
  logic [7:0] output_axis_tdata;
  logic       output_axis_tvalid;
  logic       output_axis_tlast;
  logic       out_rdy;
  logic       busy;
  logic       bus_error;

  soc_interface_wb_if #(.WB_DATA_WIDTH(DW)) wbi ();

  soc_interface_wb #(.WB_DATA_WIDTH(DW), .TIMEOUT(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (input_axis_tready),
    .input_axis_tlast   (in_last),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (out_rdy),
    .output_axis_tlast  (output_axis_tlast),
    .wb                 (wbi),
    .busy               (busy),
    .bus_error          (bus_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Wishbone slave model: 0 = ack, 1 = err, 2 = silent
  int          slave_mode;
  logic [31:0] mem [0:15];
  logic [33:0] wq_adr [$];
  logic [3:0]  wq_sel [$];
  logic [31:0] wq_dat [$];

  always @(posedge clk) begin
    if (rst) begin
      wbi.wb_ack_i <= 1'b0;
      wbi.wb_err_i <= 1'b0;
      wbi.wb_dat_i <= '0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[2] = 32'h44332211;
      mem[3] = 32'h87654321;
    end else if (wbi.wb_cyc_o && wbi.wb_stb_o && !wbi.wb_ack_i && !wbi.wb_err_i) begin
      if (slave_mode == 0) begin
        wbi.wb_ack_i <= 1'b1;
        if (wbi.wb_we_o) begin
          wq_adr.push_back(wbi.wb_adr_o);
          wq_sel.push_back(wbi.wb_sel_o);
          wq_dat.push_back(wbi.wb_dat_o);
          for (int k = 0; k < 4; k++)
            if (wbi.wb_sel_o[k]) mem[wbi.wb_adr_o[3:0]][8*k +: 8] = wbi.wb_dat_o[8*k +: 8];
        end else begin
          wbi.wb_dat_i <= mem[wbi.wb_adr_o[3:0]];
        end
      end else if (slave_mode == 1) begin
        wbi.wb_err_i <= 1'b1;
      end
    end else begin
      wbi.wb_ack_i <= 1'b0;
      wbi.wb_err_i <= 1'b0;
    end
  end

  // Output, error-pulse and bus-cycle monitors, sampled mid-period.
  logic [8:0] out_q [$];
  int berr_cnt   = 0;
  int cyc_hi     = 0;
  int cyc_starts = 0;
  logic cyc_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (output_axis_tvalid && out_rdy) out_q.push_back({output_axis_tlast, output_axis_tdata});
      if (bus_error) berr_cnt++;
      if (wbi.wb_cyc_o) cyc_hi++;
      if (wbi.wb_cyc_o && !cyc_prev) cyc_starts++;
    end
    cyc_prev = wbi.wb_cyc_o;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] frame [$];
  logic [7:0] exp_q [$];
  int out_base = 0;
  int wbase    = 0;

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!input_axis_tready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("send_ready", 64'(input_axis_tready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], i == frame.size() - 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy || wbi.wb_cyc_o || output_axis_tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle", 64'({busy, wbi.wb_cyc_o, output_axis_tvalid}), 64'(0));
  endtask

  task automatic expect_out(input string tag);
    check_eq({tag, "_count"}, 64'(out_q.size() - out_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (out_base + i < out_q.size())
        check_eq(tag, 64'(out_q[out_base + i]), 64'({i == exp_q.size() - 1, exp_q[i]}));
    out_base = out_q.size();
  endtask

  int base_starts;
  int base_hi;
  int base_berr;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_last    = 1'b0;
    out_rdy    = 1'b1;
    slave_mode = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_cyc",    64'({wbi.wb_cyc_o, wbi.wb_stb_o, wbi.wb_we_o}), 64'(0));
    check_eq("rst_sel",    64'(wbi.wb_sel_o), 64'(0));
    check_eq("rst_out",    64'({output_axis_tvalid, output_axis_tlast}), 64'(0));
    check_eq("rst_tready", 64'(input_axis_tready), 64'(0));
    check_eq("rst_flags",  64'({busy, bus_error}), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // full-word write
    wbase = wq_adr.size();
    frame = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame();
    wait_idle();
    check_eq("w1_count", 64'(wq_adr.size() - wbase), 64'(1));
    if (wq_adr.size() > wbase) begin
      check_eq("w1_adr", 64'(wq_adr[wbase]), 64'(4));
      check_eq("w1_sel", 64'(wq_sel[wbase]), 64'(4'hF));
      check_eq("w1_dat", 64'(wq_dat[wbase]), 64'(32'h44332211));
    end
    exp_q = '{};
    expect_out("w1_out");

    // two partial writes straddling a word boundary
    wbase = wq_adr.size();
    frame = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'h13, 8'hAA, 8'hBB};
    send_frame();
    wait_idle();
    check_eq("w2_count", 64'(wq_adr.size() - wbase), 64'(2));
    if (wq_adr.size() > wbase + 1) begin
      check_eq("w2a_adr", 64'(wq_adr[wbase]), 64'(4));
      check_eq("w2a_sel", 64'(wq_sel[wbase]), 64'(4'h8));
      check_eq("w2a_dat", 64'(wq_dat[wbase][31:24]), 64'(8'hAA));
      check_eq("w2b_adr", 64'(wq_adr[wbase + 1]), 64'(5));
      check_eq("w2b_sel", 64'(wq_sel[wbase + 1]), 64'(4'h1));
      check_eq("w2b_dat", 64'(wq_dat[wbase + 1][7:0]), 64'(8'hBB));
    end
    exp_q = '{};
    expect_out("w2_out");

    // three bytes from one word, one bus read
    base_starts = cyc_starts;
    frame = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h5A, 8'h5A, 8'h5A};
    send_frame();
    wait_idle();
    check_eq("r1_reads", 64'(cyc_starts - base_starts), 64'(1));
    exp_q = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h00};
    expect_out("r1_out");

    // read crossing from word 3 into word 4 (word 4 = AA332211 after the writes)
    base_starts = cyc_starts;
    frame = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h0E, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_idle();
    check_eq("r2_reads", 64'(cyc_starts - base_starts), 64'(2));
    exp_q = '{8'h01, 8'h65, 8'h87, 8'h11, 8'h00};
    expect_out("r2_out");

    // slave error on the read
    slave_mode = 1;
    base_berr  = berr_cnt;
    frame = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h01, 8'h02, 8'h03};
    send_frame();
    wait_idle();
    check_eq("err_pulse", 64'(berr_cnt - base_berr), 64'(1));
    exp_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    expect_out("err_out");

    // silent slave with a stalled response stream
    slave_mode = 2;
    out_rdy    = 1'b0;
    base_hi    = cyc_hi;
    base_berr  = berr_cnt;
    frame = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
    fork
      send_frame();
      begin
        int n;
        n = 0;
        while (!output_axis_tvalid && n < 100) begin
          @(negedge clk);
          n++;
        end
        repeat (20) @(negedge clk);
        check_eq("stall_hold", 64'({output_axis_tvalid, output_axis_tdata}), 64'({1'b1, 8'h01}));
        out_rdy = 1'b1;
      end
    join
    wait_idle();
    check_eq("tmo_cyc_len", 64'(cyc_hi - base_hi), 64'(16));
    check_eq("tmo_pulse",   64'(berr_cnt - base_berr), 64'(1));
    exp_q = '{8'h01, 8'h00, 8'h00, 8'h02};
    expect_out("tmo_out");

    // junk frame and a truncated read command
    slave_mode  = 0;
    base_starts = cyc_starts;
    frame = '{8'h55, 8'h01, 8'h02};
    send_frame();
    frame = '{8'hA0, 8'h00, 8'h00};
    send_frame();
    wait_idle();
    check_eq("noop_cycles", 64'(cyc_starts - base_starts), 64'(0));
    check_eq("noop_busy",   64'(busy), 64'(0));
    exp_q = '{};
    expect_out("noop_out");

    // reset while a read cycle is outstanding
    slave_mode = 2;
    base_berr  = berr_cnt;
    frame = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h08, 8'h11};
    send_frame();
    begin
      int n;
      n = 0;
      while (!wbi.wb_cyc_o && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("mid_cyc_seen", 64'(wbi.wb_cyc_o), 64'(1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_bus", 64'({wbi.wb_cyc_o, wbi.wb_stb_o}), 64'(0));
    check_eq("mid_rst_out", 64'({output_axis_tvalid, busy, bus_error}), 64'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("mid_pulse", 64'(berr_cnt - base_berr), 64'(0));
    check_eq("mid_out_count", 64'(out_q.size() - out_base), 64'(1));
    if (out_q.size() > out_base) check_eq("mid_out", 64'(out_q[out_base]), 64'({1'b0, 8'h01}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
    $fatal(1);
  end
endmodule

// File: doc/soc_interface_wb.md
SOC_INTERFACE_WB -- requirements
Module: soc_interface_wb

Interface
REQ-001 WB_DATA_WIDTH, 32, Wishbone data width; legal values 8, 16, 32; SEL_W = WB_DATA_WIDTH/8, LANE_BITS = log2(SEL_W).
REQ-002 TIMEOUT, 1024, max cycles a Wishbone cycle may wait for ack/err; 0 disables the timeout.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 input_axis_tdata  in  8  request byte stream.
REQ-006 input_axis_tvalid  in  1  request byte valid.
REQ-007 input_axis_tready  out  1  request byte accepted.
REQ-008 input_axis_tlast  in  1  last request byte of frame.
REQ-009 output_axis_tdata  out  8  response byte.
REQ-010 output_axis_tvalid  out  1  response byte valid.
REQ-011 output_axis_tready  in  1  response byte accepted.
REQ-012 output_axis_tlast  out  1  last response byte.
REQ-013 wb_adr_o  out  36-LANE_BITS  word address = byte_addr[35:LANE_BITS].
REQ-014 wb_dat_i / wb_dat_o  in / out  WB_DATA_WIDTH  read / write data; lane k = bits [8k+7:8k].
REQ-015 wb_sel_o  out  SEL_W  byte-lane select.
REQ-016 wb_we_o, wb_stb_o, wb_cyc_o  out  1 each  write enable, strobe, cycle.
REQ-017 wb_ack_i, wb_err_i  in  1 each  acknowledge, error.
REQ-018 busy  out  1  registered; high whenever next state is not IDLE.
REQ-019 bus_error  out  1  one-cycle pulse on each wb_err_i or timeout.

Function
REQ-020 States: IDLE, ADDR, READ, WRITE, WAIT_LAST, FINISH.
REQ-021 IDLE: byte 0xA? = read, 0xB? = write, low nibble -> byte_addr[35:32], go ADDR; any other byte -> WAIT_LAST; a byte with tlast -> stay IDLE.
REQ-022 ADDR: 4 bytes, MSB first, -> byte_addr[31:0]; tlast on any address byte -> IDLE with no Wishbone cycle and no output.
REQ-023 Address increment per data byte on [31:0] only; wraps 0xFFFFFFFF -> 0; [35:32] unchanged.
REQ-024 WRITE: each byte is placed in lane byte_addr[LANE_BITS-1:0] with its sel bit set; write issued when lane = SEL_W-1 or tlast; partial words carry only the written lanes; tready low from issue until the cycle ends.
REQ-025 WRITE produces no response bytes; errors are reported only via bus_error.
REQ-026 READ: each request byte, including the tlast byte, requests exactly one data byte at byte_addr; payload content ignored.
REQ-027 One Wishbone read per word: cached word reused for the same word address, invalidated on a word boundary crossing or a new command.
REQ-028 Response frame: 0x01 start byte, then N data bytes (lane of byte_addr), then status byte with tlast: 0x00 ok, 0x02 if any err/timeout occurred in the frame.
REQ-029 Read err/timeout: data bytes from that word are 0x00; reading continues.
REQ-030 WB cycle: cyc = stb = 1 until ack|err|timeout is sampled, all deasserted the next cycle; at most one cycle outstanding; ack and err together count as err.
REQ-031 Timeout counter starts at 0 on cycle start; abort when it reaches TIMEOUT; treated as err.
REQ-032 Output register: tvalid held with stable data until tready; no new read is issued and tready is held low while the output register is full.
REQ-033 FINISH: wait for any outstanding cycle to end, emit the status byte, -> IDLE; no new cycles after tlast.
REQ-034 WAIT_LAST: tready = 1, discard bytes until tlast, -> IDLE; no Wishbone activity, no output.
REQ-035 input_axis_tready low in IDLE while wb_cyc_o = 1.

Reset
REQ-036 rst: state IDLE; all outputs 0 (wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, tvalid, tlast, tready, busy, bus_error); cache and status cleared.
REQ-037 rst mid-cycle: cycle abandoned immediately with no pulse; a partial response frame is never completed.

Verification (WB_DATA_WIDTH=32)
REQ-038 B0 00 00 00 10 11 22 33 44(last) -> one write, adr 0x4, sel 0xF, dat 0x44332211; no output.
REQ-039 B0 00 00 00 13 AA BB(last) -> write adr 0x4 sel 0x8 dat[31:24]=AA, then write adr 0x5 sel 0x1 dat[7:0]=BB.
REQ-040 Word 0x2 = 0x44332211; A0 00 00 00 08 xx xx xx(last) -> single read adr 0x2; output 01 11 22 33 00(last).
REQ-041 Same frame with wb_err_i on the read -> output 01 00 00 00 02(last); bus_error high exactly one cycle.
REQ-042 TIMEOUT=16, no slave response -> cyc drops after 16 cycles; bus_error pulse; status 0x02; output_axis_tready stalled 20 cycles -> no byte lost or duplicated.
REQ-043 55 01 02(last) and A0 00 00(last) -> all bytes consumed; no Wishbone cycle, no output; busy back to 0.
